// File: rtl/serialize_if.sv
// rtl/serialize_if.sv - parallel word input and serial bit output bundle for serialize
//
// Signals:
//   din         parallel word offered by the upstream block
//   din_valid   din carries a word
//   din_ready   serializer holding buffer can take a word
//   sout        serial data bit
//   sout_valid  sout carries a bit this cycle
//   sout_first  sout carries the first bit of a word
//   busy        holding buffer full or shifter active
//
// Modports:
//   slave   the serializer side (consumes words, produces bits)
//   master  the side that offers words and watches the bit stream

interface serialize_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             busy;

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output sout_first,
    output busy
  );

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  sout_first,
    input  busy
  );

endinterface

// File: rtl/serialize.sv
// rtl/serialize.sv - parallel-to-serial converter with one-entry holding buffer
//
// Converts WIDTH-bit words into a gapless serial stream, one bit per clock,
// MSB first when MSB_FIRST=1 or LSB first when MSB_FIRST=0. A first-bit
// marker lets the downstream deserializer align to word boundaries.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   sync_clr  synchronous clear; drops the buffered word and the word in flight
//   bus       serialize_if.slave: din/din_valid/din_ready word input,
//             sout/sout_valid/sout_first bit output, busy status

module serialize #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync_clr,
  serialize_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             buf_full;
  logic             buf_full_nxt;
  logic [WIDTH-1:0] buf_data;
  logic [WIDTH-1:0] buf_data_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             din_ready_q;

  logic             wr;
  logic             word_end;
  logic             ld;
  logic             out_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // The bit on the wire is always at the "front" end of the shift register;
  // shifting moves the next bit into that position.
  generate
    if (MSB_FIRST) begin : g_msb
      assign out_bit       = shreg[WIDTH-1];
      assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign out_bit       = shreg[0];
      assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_nxt    = state;
    buf_full_nxt = buf_full;
    buf_data_nxt = buf_data;
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;

    // A write needs an empty buffer and a load needs a full one, so the two
    // never happen on the same edge.
    wr       = bus.din_valid && din_ready_q;
    word_end = (state == SHIFT) && (cnt == CNT_LAST);
    ld       = buf_full && ((state == IDLE) || word_end);

    case (state)
      IDLE: begin
        if (ld) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Reloading on the last bit keeps the stream gapless.
        if (word_end && !buf_full) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (ld) begin
      shreg_nxt = buf_data;
      cnt_nxt   = '0;
    end else if (state == SHIFT) begin
      shreg_nxt = shreg_shifted;
      cnt_nxt   = word_end ? '0 : cnt + 1'b1;
    end

    if (wr) begin
      buf_data_nxt = bus.din;
      buf_full_nxt = 1'b1;
    end else if (ld) begin
      buf_full_nxt = 1'b0;
    end

    // Clear wins over everything, including a transfer in the same cycle.
    if (sync_clr) begin
      state_nxt    = IDLE;
      buf_full_nxt = 1'b0;
      shreg_nxt    = '0;
      cnt_nxt      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buf_full    <= 1'b0;
      buf_data    <= '0;
      shreg       <= '0;
      cnt         <= '0;
      din_ready_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      buf_full    <= buf_full_nxt;
      buf_data    <= buf_data_nxt;
      shreg       <= shreg_nxt;
      cnt         <= cnt_nxt;
      // Registered copy of !buf_full; held low while in reset.
      din_ready_q <= !buf_full_nxt;
    end
  end

  // Outputs depend only on registered state, never on din/din_valid.
  assign bus.din_ready  = din_ready_q;
  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout       = (state == SHIFT) && out_bit;
  assign bus.sout_first = (state == SHIFT) && (cnt == '0);
  assign bus.busy       = buf_full || (state == SHIFT);

endmodule

// File: tb/tb_serialize.sv
// tb/tb_serialize.sv - scoreboard bench for serialize (MSB-first and LSB-first instances)

module tb_serialize;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic sync_clr = 1'b0;
  logic sync_clr_l = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  logic clr_flag = 1'b0;
  int   last_run = 0;

  serialize_if #(.WIDTH(8)) bm ();
  serialize_if #(.WIDTH(8)) bl ();

  serialize #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr),
    .bus      (bm)
  );

  serialize #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr_l),
    .bus      (bl)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Deserializer model plus scoreboard: rebuilds words aligned on sout_first
  // and compares each completed word against the oldest accepted word.
  logic [7:0] acc_m, acc_l, exp_w;
  int cnt_m = 0;
  int cnt_l = 0;
  int run   = 0;

  initial begin : mon
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt_m = 0;
        cnt_l = 0;
        run   = 0;
      end else begin
        if (bm.sout_valid) begin
          run++;
          check_eq("first_m", bm.sout_first, cnt_m == 0);
          acc_m = {acc_m[6:0], bm.sout};
          cnt_m++;
          if (cnt_m == 8) begin
            if (q_m.size() == 0) check_eq("sb_empty_m", q_m.size(), 1);
            else begin
              exp_w = q_m.pop_front();
              check_eq("word_m", acc_m, exp_w);
            end
            cnt_m = 0;
          end
        end else begin
          if (run != 0) begin
            last_run = run;
            run = 0;
          end
          if (cnt_m != 0) begin
            if (!clr_flag) check_eq("gap_m", cnt_m, 0);
            cnt_m = 0;
          end
        end
        if (bl.sout_valid) begin
          check_eq("first_l", bl.sout_first, cnt_l == 0);
          acc_l = {bl.sout, acc_l[7:1]};
          cnt_l++;
          if (cnt_l == 8) begin
            if (q_l.size() == 0) check_eq("sb_empty_l", q_l.size(), 1);
            else begin
              exp_w = q_l.pop_front();
              check_eq("word_l", acc_l, exp_w);
            end
            cnt_l = 0;
          end
        end else if (cnt_l != 0) begin
          check_eq("gap_l", cnt_l, 0);
          cnt_l = 0;
        end
      end
    end
  end

  // Called at a negedge; din wanders while din_ready is low, then the word is
  // presented and recorded once the handshake is guaranteed at the next edge.
  task automatic send_m(input logic [7:0] w, output int waited);
    waited = 0;
    bm.din_valid = 1'b1;
    while (!bm.din_ready && waited < 200) begin
      bm.din = 8'($urandom_range(255));
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check_eq("ready_timeout_m", waited, 0);
    bm.din = w;
    q_m.push_back(w);
    @(negedge clk);
  endtask

  task automatic send_l(input logic [7:0] w);
    int waited = 0;
    bl.din_valid = 1'b1;
    while (!bl.din_ready && waited < 200) begin
      bl.din = 8'($urandom_range(255));
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check_eq("ready_timeout_l", waited, 0);
    bl.din = w;
    q_l.push_back(w);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bm.din_valid = 1'b0;
    bl.din_valid = 1'b0;
    while ((bm.busy || bl.busy || q_m.size() != 0 || q_l.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check_eq("drain_timeout", n, 0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int w;
    int vcount;
    bm.din = '0; bm.din_valid = 1'b0;
    bl.din = '0; bl.din_valid = 1'b0;

    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", bm.din_ready, 0);
    check_eq("rst_valid", bm.sout_valid, 0);
    check_eq("rst_sout", bm.sout, 0);
    check_eq("rst_first", bm.sout_first, 0);
    check_eq("rst_busy", bm.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", bm.din_ready, 1);

    // Single word: latency and framing
    send_m(8'hA5, w);
    bm.din_valid = 1'b0;
    check_eq("lat_busy", bm.busy, 1);
    check_eq("lat_novalid", bm.sout_valid, 0);
    @(negedge clk);
    check_eq("lat_valid", bm.sout_valid, 1);
    check_eq("lat_first", bm.sout_first, 1);
    check_eq("lat_bit0", bm.sout, 1);
    drain();
    check_eq("run_single", last_run, 8);
    check_eq("idle_busy", bm.busy, 0);

    // Back-to-back with din_valid held high
    send_m(8'hFF, w);
    send_m(8'h00, w);
    send_m(8'h81, w);
    check_eq("b2b_ready_low", w > 0, 1);
    drain();
    check_eq("run_b2b", last_run, 24);

    // LSB-first instance
    send_l(8'h01);
    send_l(8'hB4);
    drain();

    // sync_clr at bit 3 of 3C with C3 buffered
    send_m(8'h3C, w);
    send_m(8'hC3, w);
    bm.din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("clr_pre_busy", bm.busy, 1);
    sync_clr = 1'b1;
    clr_flag = 1'b1;
    q_m.delete();
    @(negedge clk);
    sync_clr = 1'b0;
    check_eq("clr_valid", bm.sout_valid, 0);
    check_eq("clr_busy", bm.busy, 0);
    check_eq("clr_ready", bm.din_ready, 1);
    // transfer coinciding with sync_clr is discarded
    bm.din = 8'hEE;
    bm.din_valid = 1'b1;
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    bm.din_valid = 1'b0;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (bm.sout_valid || bm.busy) vcount++;
      @(negedge clk);
    end
    check_eq("clr_no_resume", vcount, 0);
    clr_flag = 1'b0;
    send_m(8'h5A, w);
    drain();

    // Reset mid-word
    send_m(8'h96, w);
    bm.din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    clr_flag = 1'b1;
    rst_n = 1'b0;
    q_m.delete();
    #1;
    check_eq("rstmid_valid", bm.sout_valid, 0);
    @(negedge clk);
    check_eq("rstmid_ready", bm.din_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstmid_rel_ready", bm.din_ready, 1);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (bm.sout_valid) vcount++;
      @(negedge clk);
    end
    check_eq("rstmid_no_trail", vcount, 0);
    clr_flag = 1'b0;

    // Loopback: 16 random words streamed continuously
    for (int i = 0; i < 16; i++) begin
      send_m(8'($urandom_range(255)), w);
    end
    drain();
    check_eq("run_loop", last_run, 128);

    check_eq("sb_left_m", q_m.size(), 0);
    check_eq("sb_left_l", q_l.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
